manchester_decoder: RTL and testbench

MANCHESTER_DECODER -- requirements
Module: manchester_decoder

---
 rtl/manchester_pkg.sv | 15 +
 rtl/manchester_edge_sync.sv | 37 +++
 rtl/manchester_decoder.sv | 145 ++++++++++++++
 tb/tb_manchester_decoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester (IEEE 802.3) byte decoder.
// Holds the decoder state encoding, the frame length and the default
// half-bit duration in clk cycles.
package manchester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int FRAME_BITS       = 8;
  localparam int HALF_BIT_DEFAULT = 8;

endpackage

// File: rtl/manchester_edge_sync.sv
// Two-flop synchronizer plus single-cycle edge detector for the raw line.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : raw asynchronous Manchester line
//   line_s     : synchronized line level
//   rise, fall : one-cycle strobes on synchronized line transitions
module manchester_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic line_r;
  logic line_d_r;

  // Synchronizer chain followed by a one-cycle delayed copy for edge compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= 1'b0;
      line_r   <= 1'b0;
      line_d_r <= 1'b0;
    end else begin
      meta_r   <= din;
      line_r   <= meta_r;
      line_d_r <= line_r;
    end
  end

  assign line_s = line_r;
  assign rise   = line_r & ~line_d_r;
  assign fall   = ~line_r & line_d_r;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester (IEEE 802.3: mid-bit rise = 1, mid-bit fall = 0) byte decoder.
// Frame: one sync bit (always 1) then 8 data bits MSB first, no stop bit.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   ena        : block enable, low forces IDLE without pulses
//   din        : raw Manchester line (asynchronous, idles low)
//   data_out   : last correctly decoded byte
//   data_valid : one-cycle pulse when data_out updates
//   frame_err  : one-cycle pulse when a frame is aborted by a missing edge
//   busy       : high whenever the decoder is not in IDLE
module manchester_decoder
  import manchester_pkg::*;
#(
  parameter int HALF_BIT = HALF_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  // Acceptance window for the next mid-bit edge, measured since the last one.
  // Anything earlier is a bit-boundary edge; nothing by WIN_HI is a dead line.
  localparam logic [7:0] WIN_LO = 8'(3 * HALF_BIT / 2);
  localparam logic [7:0] WIN_HI = 8'(5 * HALF_BIT / 2);

  logic       line_s;
  logic       rise;
  logic       fall;

  state_t     state_r,  state_n;
  logic [7:0] cnt_r,    cnt_n;
  logic [3:0] idx_r,    idx_n;
  logic [7:0] shift_r,  shift_n;
  logic [7:0] data_r,   data_n;
  logic       valid_r,  valid_n;
  logic       err_r,    err_n;
  logic       busy_r;

  logic       edge_s;
  logic       in_win_s;
  logic [7:0] cnt_inc_s;

  manchester_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (din),
    .line_s (line_s),
    .rise   (rise),
    .fall   (fall)
  );

  assign edge_s    = rise | fall;
  assign in_win_s  = (cnt_r >= WIN_LO) && (cnt_r <= WIN_HI);
  assign cnt_inc_s = (cnt_r == 8'hFF) ? cnt_r : (cnt_r + 8'd1);

  // Next-state, counter, shift and pulse decode
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_inc_s;
    idx_n   = idx_r;
    shift_n = shift_r;
    data_n  = data_r;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (!ena) begin
      state_n = IDLE;
      cnt_n   = 8'd0;
      idx_n   = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_n = 8'd0;
          // The rise here is the sync bit's mid-bit edge.
          if (rise) begin
            idx_n   = 4'd0;
            state_n = SYNC;
          end else begin
            idx_n   = idx_r;
          end
        end
        SYNC, DATA: begin
          if (edge_s && in_win_s) begin
            // A rise in the window encodes 1, a fall encodes 0.
            cnt_n   = 8'd0;
            shift_n = {shift_r[6:0], rise};
            if (idx_r == 4'(FRAME_BITS - 1)) begin
              data_n  = {shift_r[6:0], rise};
              valid_n = 1'b1;
              idx_n   = 4'd0;
              state_n = IDLE;
            end else begin
              idx_n   = idx_r + 4'd1;
              state_n = DATA;
            end
          end else if (cnt_r > WIN_HI) begin
            err_n   = 1'b1;
            idx_n   = 4'd0;
            state_n = IDLE;
          end else begin
            state_n = state_r;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 8'd0;
          idx_n   = 4'd0;
        end
      endcase
    end
  end

  // State and datapath registers; busy follows the registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      idx_r   <= 4'd0;
      shift_r <= 8'd0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      shift_r <= shift_n;
      data_r  <= data_n;
      valid_r <= valid_n;
      err_r   <= err_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  assign data_out   = data_r;
  assign data_valid = valid_r;
  assign frame_err  = err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_manchester_decoder.sv
// Self-checking bench for manchester_decoder at HALF_BIT = 8.
// Frames are generated from a table of mid-bit times (optionally jittered),
// expected bytes go into a scoreboard queue when a frame is driven and are
// popped when data_valid is seen.
module tb_manchester_decoder;

  localparam int HB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       din = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_mid = 0;
  int dv_cyc = -1;
  int fe_cyc = -1;
  int dv_count = 0;
  int fe_count = 0;
  int dv0;
  int fe0;
  int mid;
  logic [7:0] exp_q[$];
  int jtab[9];

  always #5 clk = ~clk;

  manchester_decoder #(.HALF_BIT(HB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .din        (din),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // One clock step; outputs are sampled on the falling edge and data_valid
  // pulses are matched against the scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (data_valid) begin
      dv_count++;
      dv_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: data_out=%02h, required no pulse", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL frame_value: data_out=%02h required %02h", data_out, e);
        end
      end
    end
    if (frame_err) begin
      fe_count++;
      fe_cyc = cyc;
    end
    if (data_valid && frame_err) begin
      checks++;
      errors++;
      $display("FAIL pulse_overlap: data_valid=1 frame_err=1, required not both");
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  // Drive sync bit plus (nbits-1) data bits of b; mid-bit k sits at 2*HB*k+jtab[k].
  task automatic drive_frame(input logic [7:0] b, input int nbits);
    logic [8:0] bits;
    int mprev;
    int m;
    int bnd;
    bits = {1'b1, b};
    din = 1'b0;
    wait_cycles(HB);
    din = 1'b1;
    last_mid = cyc;
    for (int k = 1; k < nbits; k++) begin
      mprev = 2 * HB * (k - 1) + jtab[k - 1];
      m     = 2 * HB * k + jtab[k];
      bnd   = (mprev + m) / 2;
      wait_cycles(bnd - mprev);
      din = ~bits[8 - k];
      wait_cycles(m - bnd);
      din = bits[8 - k];
      last_mid = cyc;
    end
    wait_cycles(HB);
  endtask

  task automatic go_idle();
    din = 1'b0;
    wait_cycles(40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    din = 1'b0;
    wait_cycles(3);
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %02h required 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst_n = 1'b1;
    wait_cycles(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_clean();
    dv0 = dv_count; fe0 = fe_count;
    exp_q.push_back(8'hA5);
    drive_frame(8'hA5, 9);
    go_idle();
    checks++; if (dv_count - dv0 != 1) begin errors++; $display("FAIL clean_pulses: got %0d required 1", dv_count - dv0); end
    checks++; if (dv_cyc - last_mid != 3) begin errors++; $display("FAIL clean_latency: got %0d required 3", dv_cyc - last_mid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL clean_data: got %02h required a5", data_out); end
    checks++; if (fe_count != fe0) begin errors++; $display("FAIL clean_err: got %0d required 0", fe_count - fe0); end
  endtask

  task automatic test_back_to_back();
    dv0 = dv_count;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    drive_frame(8'h00, 9);
    drive_frame(8'hFF, 9);
    go_idle();
    checks++; if (dv_count - dv0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d required 2", dv_count - dv0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d required 0", exp_q.size()); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %02h required ff", data_out); end
  endtask

  task automatic test_jitter();
    dv0 = dv_count; fe0 = fe_count;
    jtab = '{0, 3, 3, 0, -3, -3, 0, 3, 0};
    exp_q.push_back(8'h3C);
    drive_frame(8'h3C, 9);
    go_idle();
    jtab = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL jitter_data: got %02h required 3c", data_out); end
    checks++; if (dv_count - dv0 != 1) begin errors++; $display("FAIL jitter_pulses: got %0d required 1", dv_count - dv0); end
    checks++; if (fe_count != fe0) begin errors++; $display("FAIL jitter_err: got %0d required 0", fe_count - fe0); end
  endtask

  task automatic test_frame_abort();
    dv0 = dv_count; fe0 = fe_count;
    drive_frame(8'hB0, 5);
    mid = last_mid;
    din = 1'b0;
    wait_cycles(40);
    checks++; if (fe_count - fe0 != 1) begin errors++; $display("FAIL abort_err_pulses: got %0d required 1", fe_count - fe0); end
    checks++; if (fe_cyc - mid != 25) begin errors++; $display("FAIL abort_err_time: got %0d required 25", fe_cyc - mid); end
    checks++; if (dv_count != dv0) begin errors++; $display("FAIL abort_valid: got %0d required 0", dv_count - dv0); end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL abort_data: got %02h required 3c", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    dv0 = dv_count; fe0 = fe_count;
    drive_frame(8'h96, 6);
    rst_n = 1'b0;
    wait_cycles(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %02h required 00", data_out); end
    din = 1'b0;
    rst_n = 1'b1;
    wait_cycles(40);
    checks++; if (dv_count != dv0 || fe_count != fe0) begin errors++; $display("FAIL midrst_pulses: got dv=%0d fe=%0d required 0 0", dv_count - dv0, fe_count - fe0); end
    exp_q.push_back(8'h5A);
    drive_frame(8'h5A, 9);
    go_idle();
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL midrst_next_data: got %02h required 5a", data_out); end
    checks++; if (dv_count - dv0 != 1) begin errors++; $display("FAIL midrst_next_pulses: got %0d required 1", dv_count - dv0); end
  endtask

  task automatic test_enable();
    dv0 = dv_count; fe0 = fe_count;
    drive_frame(8'h81, 5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ena_busy_before: got %b required 1", busy); end
    ena = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ena_busy_drop: got %b required 0", busy); end
    drive_frame(8'h81, 9);
    go_idle();
    checks++; if (dv_count != dv0 || fe_count != fe0) begin errors++; $display("FAIL ena_pulses: got dv=%0d fe=%0d required 0 0", dv_count - dv0, fe_count - fe0); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL ena_hold: got %02h required 5a", data_out); end
    ena = 1'b1;
    wait_cycles(5);
    exp_q.push_back(8'h7E);
    drive_frame(8'h7E, 9);
    go_idle();
    checks++; if (data_out !== 8'h7E) begin errors++; $display("FAIL ena_next_data: got %02h required 7e", data_out); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ena_pending: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    jtab = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_reset();
    test_clean();
    test_back_to_back();
    test_jitter();
    test_frame_abort();
    test_reset_mid_frame();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
